fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 10 +
 rtl/fifo_drain_buf.sv | 38 +++
 rtl/fifo_drain.sv | 68 ++++++
 tb/tb_fifo_drain.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared width default, buffer depth, count type and pointer helper for fifo_drain.
package fifo_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int BUF_DEPTH = 3;
    typedef logic [1:0] count_t;

    function automatic count_t ptr_inc(input count_t p);
        return (p == count_t'(BUF_DEPTH - 1)) ? '0 : p + 2'd1;
    endfunction
endpackage

// File: rtl/fifo_drain_buf.sv
// fifo_drain_buf: 3-entry in-order skid buffer with pointers wrapping modulo 3.
module fifo_drain_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output count_t           count
);
    logic [WIDTH-1:0] mem [BUF_DEPTH];
    count_t rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != count_t'(BUF_DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + count_t'(do_push) - count_t'(do_pop);
        end
    end
endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: drains an upstream FIFO into a valid/ready stream with PKT_LEN-beat m_last framing.
// Optional FIFO_DRAIN_STATS_EN adds beat_cnt / stall_cnt counters.
module fifo_drain
    import fifo_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int PKT_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fifo_empty,
    output logic             fifo_r_en,
    input  logic [WIDTH-1:0] fifo_r_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [31:0]      beat_cnt,
    output logic [31:0]      stall_cnt
`endif
);
    localparam int BW = $clog2(PKT_LEN + 1);

    logic          inflight;
    logic          xfer;
    count_t        count;
    logic [BW-1:0] beat;

    // Reads in flight are reserved against the buffer so a returning word always has a slot.
    assign fifo_r_en = !rst && !fifo_empty && (({1'b0, count} + {2'b0, inflight}) < 3'(BUF_DEPTH));
    assign m_valid   = !rst && (count != '0);
    assign xfer      = m_valid && m_ready;
    assign m_last    = m_valid && (beat == BW'(PKT_LEN - 1));

    fifo_drain_buf #(.WIDTH(WIDTH)) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .pop  (xfer),
        .din  (fifo_r_data),
        .dout (m_data),
        .count(count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            beat     <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (xfer) beat <= (beat == BW'(PKT_LEN - 1)) ? '0 : beat + 1'b1;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (xfer) beat_cnt <= beat_cnt + 32'd1;
            if (m_valid && !m_ready) stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: queue-modelled upstream FIFO, scoreboard of expected beats and a negedge monitor.
module tb_fifo_drain;
    localparam int PKT_LEN = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       fifo_r_en;
    logic [7:0] fifo_r_data = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
`ifdef FIFO_DRAIN_STATS_EN
    logic [31:0] beat_cnt, stall_cnt;
`endif

    fifo_drain #(.WIDTH(8), .PKT_LEN(PKT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_r_data(fifo_r_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .beat_cnt   (beat_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] src[$];
    logic [8:0] exp_q[$];
    int checks = 0, passes = 0;
    int outstanding = 0, idx = 0, cyc = 0, lat_tgt = -1, ren_total = 0;
    int tb_beats = 0, tb_stalls = 0, mode = 0;
    bit r_en_s = 0, xfer_s = 0, rst_s = 1, was_rst = 1, stall_p = 0, pl = 0;
    logic [7:0] pd = '0;

    task automatic chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    endtask

    // Upstream FIFO: data appears the cycle after a sampled read strobe.
    always @(posedge clk) begin
        if (rst_s) begin
            exp_q.delete();
            outstanding = 0;
            idx = 0;
            fifo_r_data <= 8'($urandom);
        end else begin
            if (r_en_s && src.size() > 0) begin
                logic [7:0] d;
                d = src.pop_front();
                fifo_r_data <= d;
                exp_q.push_back({(idx % PKT_LEN) == PKT_LEN - 1, d});
                idx++;
            end else fifo_r_data <= 8'($urandom);
            outstanding += int'(r_en_s) - int'(xfer_s);
        end
        fifo_empty <= (src.size() == 0);
    end

    always @(posedge clk) begin
        #1;
        if (mode == 0) m_ready = 1'b1;
        else if (mode == 1) m_ready = 1'($urandom_range(0, 1));
        else if (mode == 2) m_ready = !m_ready;
        else m_ready = 1'b0;
    end

    always @(negedge clk) begin
        cyc++;
        r_en_s = fifo_r_en;
        xfer_s = m_valid && m_ready;
        rst_s  = rst;
        if (rst) begin
            chk("rst_outs", !m_valid && !m_last && !fifo_r_en, 64'({m_valid, m_last, fifo_r_en}), 64'(0));
            lat_tgt = -1;
            tb_beats = 0;
            tb_stalls = 0;
        end else begin
            if (was_rst) chk("post_rst", m_data == 8'h00 && !m_valid, 64'({m_valid, m_data}), 64'(0));
            chk("r_en", fifo_r_en == (!fifo_empty && outstanding < 3), 64'(fifo_r_en), 64'(!fifo_empty && outstanding < 3));
            if (outstanding == 0) chk("idle_valid", !m_valid, 64'(m_valid), 64'(0));
            if (cyc == lat_tgt) chk("latency", m_valid, 64'(m_valid), 64'(1));
            if (outstanding == 0 && fifo_r_en) lat_tgt = cyc + 2;
            if (stall_p) chk("hold", m_valid && m_data == pd && m_last == pl, 64'({m_valid, m_last, m_data}), 64'({1'b1, pl, pd}));
            if (m_valid && m_ready) begin
                tb_beats++;
                if (exp_q.size() == 0) chk("extra_beat", 1'b0, 64'(m_data), 64'(0));
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    chk("beat", {m_last, m_data} == e, 64'({m_last, m_data}), 64'(e));
                end
            end
            if (m_valid && !m_ready) tb_stalls++;
        end
        was_rst = rst;
        stall_p = !rst && m_valid && !m_ready;
        pd = m_data;
        pl = m_last;
        if (fifo_r_en) ren_total++;
    end

    task automatic wait_drain(input int limit);
        bit done = 0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk);
            #2;
            done = (src.size() == 0 && outstanding == 0 && exp_q.size() == 0);
        end
        chk("drain", done, 64'(exp_q.size() + src.size()), 64'(0));
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        int r0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        @(posedge clk);
        #1 src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33);
        wait_drain(50);

        mode = 3;
        @(posedge clk);
        #1 r0 = ren_total;
        for (int i = 0; i < 6; i++) src.push_back(8'(8'hA0 + i));
        repeat (10) @(posedge clk);
        #2;
        chk("stall_reads", ren_total - r0 == 3, 64'(ren_total - r0), 64'(3));
        chk("stall_head", m_valid && m_data == 8'hA0, 64'(m_data), 64'hA0);
        mode = 0;
        wait_drain(50);

        pulse_rst();
        @(posedge clk);
        #1 for (int i = 0; i < 8; i++) src.push_back(8'(8'h40 + i));
        wait_drain(50);

        mode = 2;
        @(posedge clk);
        #1 for (int i = 0; i < 20; i++) src.push_back(8'(8'h60 + i));
        wait_drain(100);

        mode = 1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1 if ($urandom_range(0, 1) == 1) src.push_back(8'($urandom));
        end
        wait_drain(600);

        mode = 3;
        @(posedge clk);
        #1 for (int i = 0; i < 6; i++) src.push_back(8'(8'hC0 + i));
        for (int i = 0; i < 20 && outstanding != 3; i++) begin
            @(posedge clk);
            #2;
        end
        chk("pre_rst_fill", outstanding == 3, 64'(outstanding), 64'(3));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        mode = 0;
        wait_drain(50);

`ifdef FIFO_DRAIN_STATS_EN
        mode = 1;
        @(posedge clk);
        #1 for (int i = 0; i < 12; i++) src.push_back(8'($urandom));
        wait_drain(100);
        chk("beat_cnt", beat_cnt == 32'(tb_beats), 64'(beat_cnt), 64'(tb_beats));
        chk("stall_cnt", stall_cnt == 32'(tb_stalls), 64'(stall_cnt), 64'(tb_stalls));
        pulse_rst();
        #1;
        chk("stats_rst", beat_cnt == 0 && stall_cnt == 0, 64'({beat_cnt, stall_cnt}), 64'(0));
`endif
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
